// File: rtl/store_sequence_checker.sv
// Snoops the MIPS data-memory write port and matches stores, in order, against a
// programmed table of (address, data) pairs. Reports sticky pass/fail with a cause code.
module store_sequence_checker #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          NUM_EXP     = 4,
    parameter int          TIMEOUT     = 1000,
    parameter int unsigned IGNORE_ADDR = 80,
    localparam int         IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int         CNT_W       = $clog2(NUM_EXP) + 1,
    localparam int         CYC_W       = $clog2(TIMEOUT) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [CNT_W-1:0]  exp_count,
    input  logic              ign_en,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CYC_W-1:0]  cycle_cnt
);

    localparam logic [ADDR_W-1:0] IGN_ADDR  = ADDR_W'(IGNORE_ADDR);
    localparam logic [CNT_W-1:0]  NUM_EXP_C = CNT_W'(NUM_EXP);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_tableAddr [NUM_EXP];
    logic [DATA_W-1:0] r_tableData [NUM_EXP];
    logic [CNT_W-1:0]  r_expCount;
    logic              r_ignEn;
    logic [CNT_W-1:0]  r_matchCnt;
    logic [CYC_W-1:0]  r_cycleCnt;
    logic [1:0]        r_failCode;

    logic [IDX_W-1:0]  w_idx;
    logic              w_store;
    logic              w_addrOk;
    logic              w_dataOk;
    logic [CNT_W-1:0]  w_matchInc;
    logic [CNT_W-1:0]  w_countClamp;
    logic [CYC_W-1:0]  w_cycInc;
    logic [CYC_W-1:0]  w_cycNext;
    logic              w_timeout;

    // Case equality so that X/Z on the snooped bus never counts as a match in simulation.
    assign w_idx        = r_matchCnt[IDX_W-1:0];
    assign w_store      = memwrite && !(r_ignEn && (dataadr == IGN_ADDR));
    assign w_addrOk     = (dataadr === r_tableAddr[w_idx]);
    assign w_dataOk     = (writedata === r_tableData[w_idx]);
    assign w_matchInc   = r_matchCnt + CNT_W'(1);
    assign w_countClamp = ((exp_count == '0) || (exp_count > NUM_EXP_C)) ? NUM_EXP_C : exp_count;

    // Cycle counter saturates at TIMEOUT-1; the edge that lands it there is the timeout edge.
    assign w_cycInc  = r_cycleCnt + CYC_W'(1);
    assign w_timeout = (w_cycInc >= CYC_LAST);
    assign w_cycNext = w_timeout ? CYC_LAST : w_cycInc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_PASS, S_FAIL: if (start) w_next = S_RUN;
            S_RUN: begin
                if (w_store) begin
                    if (!w_addrOk || !w_dataOk)      w_next = S_FAIL;
                    else if (w_matchInc == r_expCount) w_next = S_PASS;
                end else if (w_timeout) begin
                    w_next = S_FAIL;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == S_RUN);
        pass      = (r_state == S_PASS);
        fail      = (r_state == S_FAIL);
        fail_code = r_failCode;
        match_cnt = r_matchCnt;
        cycle_cnt = r_cycleCnt;
    end

    // Table is writable whenever no check is running; counters freeze outside RUN until restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                r_tableAddr[i] <= '0;
                r_tableData[i] <= '0;
            end
            r_expCount <= '0;
            r_ignEn    <= 1'b0;
            r_matchCnt <= '0;
            r_cycleCnt <= '0;
            r_failCode <= 2'd0;
        end else begin
            if (exp_we && (r_state != S_RUN) && (int'(exp_idx) < NUM_EXP)) begin
                r_tableAddr[exp_idx] <= exp_addr;
                r_tableData[exp_idx] <= exp_data;
            end
            if (r_state != S_RUN) begin
                if (start) begin
                    r_expCount <= w_countClamp;
                    r_ignEn    <= ign_en;
                    r_matchCnt <= '0;
                    r_cycleCnt <= '0;
                    r_failCode <= 2'd0;
                end
            end else begin
                r_cycleCnt <= w_cycNext;
                if (w_store) begin
                    if (!w_addrOk)      r_failCode <= 2'd1;
                    else if (!w_dataOk) r_failCode <= 2'd2;
                    else                r_matchCnt <= w_matchInc;
                end else if (w_timeout) begin
                    r_failCode <= 2'd3;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_sequence_checker.sv
// Bench for store_sequence_checker: directed scenarios plus randomized runs checked
// against a cycle-level reference model of the store-matching rules.
module tb_store_sequence_checker;

    localparam int TIMEOUT = 16;
    localparam int NUM_EXP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exp_we = 1'b0;
    logic [1:0]  exp_idx = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [2:0]  exp_count = '0;
    logic        ign_en = 1'b0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [2:0]  match_cnt;
    logic [4:0]  cycle_cnt;

    int nCmp = 0;
    int nErr = 0;

    // Reference model state
    bit          mBusy, mPass, mFail, mIgn;
    int          mCode, mMatch, mCycle, mCount;
    logic [31:0] mAddr [NUM_EXP];
    logic [31:0] mData [NUM_EXP];

    store_sequence_checker #(
        .ADDR_W(32), .DATA_W(32), .NUM_EXP(NUM_EXP), .TIMEOUT(TIMEOUT), .IGNORE_ADDR(80)
    ) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_count(exp_count),
        .ign_en(ign_en), .start(start), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .busy(busy), .pass(pass), .fail(fail),
        .fail_code(fail_code), .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void modelClear();
        mBusy = 0; mPass = 0; mFail = 0; mIgn = 0;
        mCode = 0; mMatch = 0; mCycle = 0; mCount = 0;
        for (int i = 0; i < NUM_EXP; i++) begin
            mAddr[i] = '0;
            mData[i] = '0;
        end
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        bit decided;
        if (!mBusy) begin
            if (exp_we) begin
                mAddr[exp_idx] = exp_addr;
                mData[exp_idx] = exp_data;
            end
            if (start) begin
                mBusy = 1; mPass = 0; mFail = 0; mCode = 0; mMatch = 0; mCycle = 0;
                mCount = (exp_count == 0 || exp_count > NUM_EXP) ? NUM_EXP : int'(exp_count);
                mIgn = ign_en;
            end
        end else begin
            decided = 0;
            if (memwrite && !(mIgn && dataadr == 32'd80)) begin
                decided = 1;
                if (dataadr != mAddr[mMatch]) begin
                    mBusy = 0; mFail = 1; mCode = 1;
                end else if (writedata != mData[mMatch]) begin
                    mBusy = 0; mFail = 1; mCode = 2;
                end else begin
                    mMatch++;
                    if (mMatch == mCount) begin
                        mBusy = 0; mPass = 1;
                    end
                end
            end
            mCycle++;
            if (mCycle >= TIMEOUT - 1) begin
                mCycle = TIMEOUT - 1;
                if (!decided) begin
                    mBusy = 0; mFail = 1; mCode = 3;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        start = 0; exp_we = 0; memwrite = 0;
    endtask

    task automatic applyReset();
        reset = 0;
        modelClear();
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic loadEntry(input int idx, input logic [31:0] a, input logic [31:0] d);
        exp_we = 1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
        tick();
    endtask

    task automatic startRun(input int cnt, input bit ign);
        start = 1; exp_count = 3'(cnt); ign_en = ign;
        tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        tick();
    endtask

    task automatic test_reset();
        applyReset();
        nCmp++;
        if ({busy, pass, fail} !== 3'b000) begin
            nErr++; $display("[TB] FAIL reset_flags got %b want 000", {busy, pass, fail});
        end
        nCmp++;
        if ({fail_code, match_cnt, cycle_cnt} !== 10'd0) begin
            nErr++; $display("[TB] FAIL reset_counters got code=%0d match=%0d cyc=%0d want 0",
                             fail_code, match_cnt, cycle_cnt);
        end
    endtask

    task automatic test_ignore();
        loadEntry(0, 32'd84, 32'd7);
        startRun(1, 1);
        store(32'd80, 32'd1);
        nCmp++;
        if (busy !== 1'b1 || fail !== 1'b0) begin
            nErr++; $display("[TB] FAIL ignore_skip got busy=%b fail=%b want 1 0", busy, fail);
        end
        store(32'd84, 32'd7);
        nCmp++;
        if (pass !== 1'b1 || fail !== 1'b0 || match_cnt !== 3'd1) begin
            nErr++; $display("[TB] FAIL ignore_pass got pass=%b fail=%b match=%0d want 1 0 1",
                             pass, fail, match_cnt);
        end
    endtask

    task automatic test_addr_mismatch();
        startRun(1, 0);
        store(32'd80, 32'd1);
        nCmp++;
        if (fail !== 1'b1 || fail_code !== 2'd1 || match_cnt !== 3'd0) begin
            nErr++; $display("[TB] FAIL addr_mismatch got fail=%b code=%0d match=%0d want 1 1 0",
                             fail, fail_code, match_cnt);
        end
    endtask

    task automatic test_data_mismatch();
        startRun(1, 0);
        store(32'd84, 32'd6);
        nCmp++;
        if (fail !== 1'b1 || fail_code !== 2'd2 || busy !== 1'b0) begin
            nErr++; $display("[TB] FAIL data_mismatch got fail=%b code=%0d busy=%b want 1 2 0",
                             fail, fail_code, busy);
        end
        store(32'd84, 32'd7);
        nCmp++;
        if (fail !== 1'b1 || pass !== 1'b0 || fail_code !== 2'd2) begin
            nErr++; $display("[TB] FAIL sticky_fail got fail=%b pass=%b code=%0d want 1 0 2",
                             fail, pass, fail_code);
        end
    endtask

    task automatic test_timeout();
        int n;
        startRun(1, 0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        nCmp++;
        if (n !== TIMEOUT - 1) begin
            nErr++; $display("[TB] FAIL timeout_cycles got %0d want %0d", n, TIMEOUT - 1);
        end
        nCmp++;
        if (fail !== 1'b1 || fail_code !== 2'd3 || cycle_cnt !== 5'd15) begin
            nErr++; $display("[TB] FAIL timeout_state got fail=%b code=%0d cyc=%0d want 1 3 15",
                             fail, fail_code, cycle_cnt);
        end
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 4; k++) loadEntry(k, 32'(4 * k), 32'(k + 1));
        startRun(4, 0);
        nCmp++;
        if (busy !== 1'b1 || match_cnt !== 3'd0 || cycle_cnt !== 5'd0) begin
            nErr++; $display("[TB] FAIL seq_start got busy=%b match=%0d cyc=%0d want 1 0 0",
                             busy, match_cnt, cycle_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) start = 1;
            store(32'(4 * k), 32'(k + 1));
            nCmp++;
            if (match_cnt !== 3'(k + 1) || pass !== (k == 3)) begin
                nErr++; $display("[TB] FAIL seq_step%0d got match=%0d pass=%b want %0d %b",
                                 k, match_cnt, pass, k + 1, (k == 3));
            end
        end
        startRun(0, 0);
        nCmp++;
        if (busy !== 1'b1 || match_cnt !== 3'd0 || cycle_cnt !== 5'd0 || pass !== 1'b0) begin
            nErr++; $display("[TB] FAIL seq_restart got busy=%b match=%0d cyc=%0d pass=%b",
                             busy, match_cnt, cycle_cnt, pass);
        end
        for (int k = 0; k < 4; k++) store(32'(4 * k), 32'(k + 1));
        nCmp++;
        if (pass !== 1'b1 || match_cnt !== 3'd4 || cycle_cnt !== 5'd4) begin
            nErr++; $display("[TB] FAIL seq_repass got pass=%b match=%0d cyc=%0d want 1 4 4",
                             pass, match_cnt, cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        startRun(4, 0);
        store(32'd0, 32'd1);
        store(32'd4, 32'd2);
        #2 reset = 0;
        #1;
        nCmp++;
        if (busy !== 1'b0 || match_cnt !== 3'd0 || cycle_cnt !== 5'd0 || pass !== 1'b0) begin
            nErr++; $display("[TB] FAIL async_reset got busy=%b match=%0d cyc=%0d pass=%b want 0",
                             busy, match_cnt, cycle_cnt, pass);
        end
        modelClear();
        @(negedge clk);
        reset = 1;
        startRun(1, 0);
        store(32'd0, 32'd0);
        nCmp++;
        if (pass !== 1'b1 || match_cnt !== 3'd1) begin
            nErr++; $display("[TB] FAIL cleared_table got pass=%b match=%0d want 1 1",
                             pass, match_cnt);
        end
    endtask

    task automatic test_random();
        logic [12:0] got, want;
        int sel, n;
        for (int run = 0; run < 30; run++) begin
            for (int w = 0; w < $urandom_range(0, 4); w++)
                loadEntry($urandom_range(0, 3), 32'($urandom_range(0, 31) * 4), 32'($urandom_range(0, 15)));
            startRun($urandom_range(0, 7), $urandom_range(0, 1));
            n = 0;
            while (mBusy && n < 40) begin
                sel = $urandom_range(0, 99);
                if (sel < 50) begin
                    memwrite = 1; dataadr = mAddr[mMatch]; writedata = mData[mMatch];
                end else if (sel < 65) begin
                    memwrite = 1; dataadr = 32'd80; writedata = 32'($urandom_range(0, 15));
                end else if (sel < 72) begin
                    memwrite = 1; dataadr = mAddr[mMatch]; writedata = mData[mMatch] ^ 32'h1;
                end else if (sel < 76) begin
                    memwrite = 1; dataadr = mAddr[mMatch] ^ 32'h4; writedata = mData[mMatch];
                end
                if ($urandom_range(0, 9) == 0) start = 1;
                tick();
                n++;
                got  = {busy, pass, fail, fail_code, match_cnt, cycle_cnt};
                want = {mBusy, mPass, mFail, 2'(mCode), 3'(mMatch), 5'(mCycle)};
                nCmp++;
                if (got !== want) begin
                    nErr++; $display("[TB] FAIL rnd run%0d cyc%0d got %h want %h", run, n, got, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_addr_mismatch();
        test_data_mismatch();
        test_timeout();
        test_sequence();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
